// File: rtl/bridge_bus_arbiter.sv
// Two-master arbiter for the single Bridge port: registered grant, burst limit, round-robin on contention.
// Define BRIDGE_ARB_FIXED_PRIO_EN for fixed M0 priority, with the burst limit applied to M1 only.
module bridge_bus_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_done,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m_rd,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wd,
    output logic [3:0]  bus_byteen,
    input  logic [31:0] bus_rd
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             burst_end;
`ifndef BRIDGE_ARB_FIXED_PRIO_EN
    logic             rr_q, rr_d;  // 0: M0 wins next IDLE contention, 1: M1
`endif

    assign cnt_inc   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    assign burst_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifndef BRIDGE_ARB_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_OWN0: begin
                if (m0_req) begin
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
                    cnt_d = cnt_inc;
`else
                    if (burst_end && m1_req) begin
                        state_d = S_OWN1;
                        cnt_d   = '0;
                        rr_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`endif
                end else begin
                    state_d = m1_req ? S_OWN1 : S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_OWN1: begin
                if (m1_req) begin
                    if (burst_end && m0_req) begin
                        state_d = S_OWN0;
                        cnt_d   = '0;
`ifndef BRIDGE_ARB_FIXED_PRIO_EN
                        rr_d    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = m0_req ? S_OWN0 : S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
                if (m0_req && m1_req) begin
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
                    state_d = S_OWN0;
`else
                    state_d = rr_q ? S_OWN1 : S_OWN0;
`endif
                end else if (m0_req) begin
                    state_d = S_OWN0;
                end else if (m1_req) begin
                    state_d = S_OWN1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifndef BRIDGE_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign m0_gnt  = (state_q == S_OWN0);
    assign m1_gnt  = (state_q == S_OWN1);
    assign m0_done = m0_req & m0_gnt;
    assign m1_done = m1_req & m1_gnt;
    assign m_rd    = bus_rd;

    // Bus is driven only during a beat, so byteen can never produce a stray write.
    always_comb begin
        bus_addr   = '0;
        bus_wd     = '0;
        bus_byteen = '0;
        if (m0_done) begin
            bus_addr   = m0_addr;
            bus_wd     = m0_wd;
            bus_byteen = m0_byteen;
        end else if (m1_done) begin
            bus_addr   = m1_addr;
            bus_wd     = m1_wd;
            bus_byteen = m1_byteen;
        end
    end

endmodule
